pkt_ctrl_50: RTL and testbench

PKT_CTRL_50 -- requirements
Module: pkt_ctrl_50

---
 rtl/pkt_ctrl_50.sv | 163 ++++++++++++++++
 tb/tb_pkt_ctrl_50.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_ctrl_50.sv
// Packet framing controller: detects header bytes from a byte-serial deserialiser,
// forwards the payload into a downstream FIFO, and reports overflow/timeout aborts.
module pkt_ctrl_50 #(
  parameter int unsigned PAYLOAD_LEN   = 4,
  parameter logic [7:0]  HDR_A         = 8'hA5,
  parameter logic [7:0]  HDR_B         = 8'hC3,
  parameter int unsigned TIMEOUT_CYC   = 64,
  parameter bit          RESYNC_ON_HDR = 1'b0
) (
  input  logic       clk_50,
  input  logic       reset_n,
  input  logic       data_ena,
  input  logic [7:0] parallel_data,
  input  logic       fifo_full,
  output logic       wr_fifo,
  output logic [7:0] wr_data,
  output logic       pkt_done,
  output logic [7:0] byte_idx,
  output logic       in_pkt,
  output logic       ovf_err,
  output logic       tmo_err,
  output logic [7:0] err_cnt
);

  localparam logic [7:0]  LastIdx = 8'(PAYLOAD_LEN - 1);
  localparam logic [15:0] TmoLast = 16'(TIMEOUT_CYC - 1);

  typedef enum logic [0:0] {StIdle, StPayload} state_e;

  state_e      state_q, state_d;
  logic        data_ena_q;
  logic        wr_fifo_q, wr_fifo_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        pkt_done_q, pkt_done_d;
  logic [7:0]  byte_idx_q, byte_idx_d;
  logic        ovf_err_q, ovf_err_d;
  logic        tmo_err_q, tmo_err_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic [15:0] idle_cnt_q, idle_cnt_d;

  logic byte_valid;
  logic is_hdr;
  logic resync_hit;
  logic tmo_hit;

  // A byte is complete on the falling edge of data_ena.
  assign byte_valid = ~data_ena & data_ena_q;
  assign is_hdr     = (parallel_data == HDR_A) || (parallel_data == HDR_B);
  assign resync_hit = RESYNC_ON_HDR && is_hdr;
  // An arriving byte wins over a timeout landing in the same cycle.
  assign tmo_hit    = ~byte_valid && (idle_cnt_q == TmoLast);

  // State register.
  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (byte_valid && is_hdr) state_d = StPayload;
      end
      StPayload: begin
        if (byte_valid) begin
          if (!resync_hit && (fifo_full || (byte_idx_q == LastIdx))) state_d = StIdle;
        end else if (tmo_hit) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Next values for the registered outputs and the idle counter.
  always_comb begin
    wr_fifo_d  = 1'b0;
    pkt_done_d = 1'b0;
    ovf_err_d  = 1'b0;
    tmo_err_d  = 1'b0;
    wr_data_d  = wr_data_q;
    byte_idx_d = byte_idx_q;
    idle_cnt_d = idle_cnt_q;
    unique case (state_q)
      StIdle: begin
        idle_cnt_d = '0;
        if (byte_valid && is_hdr) byte_idx_d = '0;
      end
      StPayload: begin
        if (byte_valid) begin
          idle_cnt_d = '0;
          if (resync_hit) begin
            byte_idx_d = '0;
          end else if (fifo_full) begin
            ovf_err_d  = 1'b1;
            byte_idx_d = '0;
          end else begin
            wr_fifo_d = 1'b1;
            wr_data_d = parallel_data;
            if (byte_idx_q == LastIdx) begin
              pkt_done_d = 1'b1;
              byte_idx_d = '0;
            end else begin
              byte_idx_d = byte_idx_q + 8'd1;
            end
          end
        end else if (tmo_hit) begin
          tmo_err_d  = 1'b1;
          byte_idx_d = '0;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + 16'd1;
        end
      end
      default: begin
        byte_idx_d = '0;
        idle_cnt_d = '0;
      end
    endcase
    err_cnt_d = err_cnt_q;
    if ((ovf_err_d || tmo_err_d) && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  // Output and datapath registers.
  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      data_ena_q <= 1'b0;
      wr_fifo_q  <= 1'b0;
      wr_data_q  <= '0;
      pkt_done_q <= 1'b0;
      byte_idx_q <= '0;
      ovf_err_q  <= 1'b0;
      tmo_err_q  <= 1'b0;
      err_cnt_q  <= '0;
      idle_cnt_q <= '0;
    end else begin
      data_ena_q <= data_ena;
      wr_fifo_q  <= wr_fifo_d;
      wr_data_q  <= wr_data_d;
      pkt_done_q <= pkt_done_d;
      byte_idx_q <= byte_idx_d;
      ovf_err_q  <= ovf_err_d;
      tmo_err_q  <= tmo_err_d;
      err_cnt_q  <= err_cnt_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  assign wr_fifo  = wr_fifo_q;
  assign wr_data  = wr_data_q;
  assign pkt_done = pkt_done_q;
  assign byte_idx = byte_idx_q;
  assign in_pkt   = (state_q == StPayload);
  assign ovf_err  = ovf_err_q;
  assign tmo_err  = tmo_err_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_pkt_ctrl_50.sv
// Bench for pkt_ctrl_50: two instances (payload headers as data / as resync) share
// random and directed stimulus and are compared every cycle against a packet-level model.
module tb_pkt_ctrl_50;

  localparam int PL  = 4;
  localparam int TMO = 64;

  logic       clk_50 = 1'b0;
  logic       reset_n;
  logic       data_ena;
  logic [7:0] parallel_data;
  logic       fifo_full;

  logic [1:0] wr_fifo, pkt_done, in_pkt, ovf_err, tmo_err;
  logic [7:0] wr_data [2];
  logic [7:0] byte_idx [2];
  logic [7:0] err_cnt [2];

  int checks = 0;
  int errors = 0;

  always #10 clk_50 = ~clk_50;

  pkt_ctrl_50 #(.RESYNC_ON_HDR(1'b0)) dut0 (
    .clk_50(clk_50), .reset_n(reset_n), .data_ena(data_ena),
    .parallel_data(parallel_data), .fifo_full(fifo_full),
    .wr_fifo(wr_fifo[0]), .wr_data(wr_data[0]), .pkt_done(pkt_done[0]),
    .byte_idx(byte_idx[0]), .in_pkt(in_pkt[0]), .ovf_err(ovf_err[0]),
    .tmo_err(tmo_err[0]), .err_cnt(err_cnt[0])
  );

  pkt_ctrl_50 #(.RESYNC_ON_HDR(1'b1)) dut1 (
    .clk_50(clk_50), .reset_n(reset_n), .data_ena(data_ena),
    .parallel_data(parallel_data), .fifo_full(fifo_full),
    .wr_fifo(wr_fifo[1]), .wr_data(wr_data[1]), .pkt_done(pkt_done[1]),
    .byte_idx(byte_idx[1]), .in_pkt(in_pkt[1]), .ovf_err(ovf_err[1]),
    .tmo_err(tmo_err[1]), .err_cnt(err_cnt[1])
  );

  // Packet-level model: where we are in the packet, how long it has been quiet.
  typedef struct packed {
    bit       ena_d;
    bit       in_pkt;
    int       pos;
    int       quiet;
    int       errs;
    bit [7:0] data;
    bit       wr;
    bit       done;
    bit       ovf;
    bit       tmo;
  } m_t;

  m_t m [2];
  bit armed = 1'b0;

  function automatic m_t step(m_t s, bit resync, bit rst_n, bit ena, bit [7:0] pd, bit full);
    m_t n;
    bit bv, hdr;
    n = s;
    n.wr = 0; n.done = 0; n.ovf = 0; n.tmo = 0;
    if (!rst_n) begin
      n = '0;
      return n;
    end
    bv = !ena && s.ena_d;
    n.ena_d = ena;
    hdr = (pd == 8'hA5) || (pd == 8'hC3);
    if (!s.in_pkt) begin
      if (bv && hdr) begin
        n.in_pkt = 1; n.pos = 0; n.quiet = 0;
      end
    end else if (bv) begin
      n.quiet = 0;
      if (resync && hdr) begin
        n.pos = 0;
      end else if (full) begin
        n.ovf = 1; n.in_pkt = 0; n.pos = 0;
      end else begin
        n.wr = 1; n.data = pd; n.pos = s.pos + 1;
        if (n.pos == PL) begin
          n.done = 1; n.in_pkt = 0; n.pos = 0;
        end
      end
    end else begin
      n.quiet = s.quiet + 1;
      if (n.quiet == TMO) begin
        n.tmo = 1; n.in_pkt = 0; n.pos = 0; n.quiet = 0;
      end
    end
    if (n.ovf || n.tmo) n.errs = (s.errs < 255) ? s.errs + 1 : 255;
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model update on the active edge.
  always @(posedge clk_50) begin
    for (int r = 0; r < 2; r++) begin
      m[r] <= step(m[r], r == 1, reset_n, data_ena, parallel_data, fifo_full);
    end
    if (!reset_n) armed <= 1'b1;
  end

  // Compare all outputs every cycle, away from the active edge.
  always @(negedge clk_50) begin
    if (armed) begin
      for (int r = 0; r < 2; r++) begin
        chk($sformatf("dut%0d.wr_fifo", r), 32'(wr_fifo[r]), 32'(m[r].wr));
        chk($sformatf("dut%0d.wr_data", r), 32'(wr_data[r]), 32'(m[r].data));
        chk($sformatf("dut%0d.pkt_done", r), 32'(pkt_done[r]), 32'(m[r].done));
        chk($sformatf("dut%0d.byte_idx", r), 32'(byte_idx[r]), 32'(m[r].pos));
        chk($sformatf("dut%0d.in_pkt", r), 32'(in_pkt[r]), 32'(m[r].in_pkt));
        chk($sformatf("dut%0d.ovf_err", r), 32'(ovf_err[r]), 32'(m[r].ovf));
        chk($sformatf("dut%0d.tmo_err", r), 32'(tmo_err[r]), 32'(m[r].tmo));
        chk($sformatf("dut%0d.err_cnt", r), 32'(err_cnt[r]), 32'(m[r].errs));
      end
    end
  end

  // One deserialised byte; returns at the negedge where its effect is visible.
  task automatic send(input logic [7:0] b, input logic full);
    @(negedge clk_50);
    data_ena = 1'b1;
    parallel_data = 8'($urandom);
    fifo_full = 1'($urandom);
    @(negedge clk_50);
    data_ena = 1'b0;
    parallel_data = b;
    fifo_full = full;
    @(negedge clk_50);
    fifo_full = 1'b0;
  endtask

  task automatic wait_tmo(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk_50);
      if (tmo_err[0]) seen = 1'b1;
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk_50);
    reset_n = 1'b0;
    data_ena = 1'b0;
    @(negedge clk_50);
    @(negedge clk_50);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [7:0] seq35 [4];
    logic [7:0] seq39 [7];
    seq35 = '{8'h11, 8'h22, 8'h33, 8'h44};
    seq39 = '{8'hA5, 8'h11, 8'hA5, 8'h22, 8'h33, 8'h44, 8'h55};

    reset_n = 1'b0; data_ena = 1'b0; parallel_data = 8'h00; fifo_full = 1'b0;
    repeat (2) @(negedge clk_50);
    chk("rst.wr_fifo", 32'(wr_fifo[0]), 32'd0);
    chk("rst.in_pkt", 32'(in_pkt[0]), 32'd0);
    chk("rst.err_cnt", 32'(err_cnt[0]), 32'd0);
    reset_n = 1'b1;

    // Basic packet.
    send(8'hA5, 1'b0);
    chk("hdr.in_pkt", 32'(in_pkt[0]), 32'd1);
    chk("hdr.wr_fifo", 32'(wr_fifo[0]), 32'd0);
    for (int i = 0; i < 4; i++) begin
      send(seq35[i], 1'b0);
      chk("pkt.wr_fifo", 32'(wr_fifo[0]), 32'd1);
      chk("pkt.wr_data", 32'(wr_data[0]), 32'(seq35[i]));
      chk("pkt.pkt_done", 32'(pkt_done[0]), (i == 3) ? 32'd1 : 32'd0);
    end
    chk("pkt.in_pkt_fall", 32'(in_pkt[0]), 32'd0);
    chk("pkt.byte_idx", 32'(byte_idx[0]), 32'd0);

    // Non-header ignored, second header accepted.
    send(8'h00, 1'b0);
    chk("ign.in_pkt", 32'(in_pkt[0]), 32'd0);
    send(8'hC3, 1'b0);
    chk("hdrb.in_pkt", 32'(in_pkt[0]), 32'd1);
    send(8'h5A, 1'b0);
    chk("5a.wr_data", 32'(wr_data[0]), 32'h5A);
    chk("5a.byte_idx", 32'(byte_idx[0]), 32'd1);
    wait_tmo("tmo1.seen");
    chk("tmo1.err_cnt", 32'(err_cnt[0]), 32'd1);

    // Overflow drop.
    send(8'hA5, 1'b0);
    send(8'h11, 1'b0);
    send(8'h22, 1'b1);
    chk("ovf.wr_fifo", 32'(wr_fifo[0]), 32'd0);
    chk("ovf.ovf_err", 32'(ovf_err[0]), 32'd1);
    chk("ovf.err_cnt", 32'(err_cnt[0]), 32'd2);
    chk("ovf.in_pkt", 32'(in_pkt[0]), 32'd0);

    // Timeout abort.
    send(8'hC3, 1'b0);
    send(8'h11, 1'b0);
    wait_tmo("tmo2.seen");
    chk("tmo2.err_cnt", 32'(err_cnt[0]), 32'd3);
    chk("tmo2.byte_idx", 32'(byte_idx[0]), 32'd0);
    chk("tmo2.in_pkt", 32'(in_pkt[0]), 32'd0);

    // Header inside payload: data for dut0, resync for dut1.
    for (int i = 0; i < 7; i++) begin
      send(seq39[i], 1'b0);
      if (i == 3) chk("rsy.dut1_idx", 32'(byte_idx[1]), 32'd1);
      if (i == 4) chk("rsy.dut0_done", 32'(pkt_done[0]), 32'd1);
      if (i == 6) begin
        chk("rsy.dut1_wr", 32'(wr_data[1]), 32'h55);
        chk("rsy.dut1_done", 32'(pkt_done[1]), 32'd1);
        chk("rsy.dut0_idle", 32'(wr_fifo[0]), 32'd0);
      end
    end

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk_50);
      if ($urandom_range(0, 99) < 2) begin
        data_ena = 1'b0;
        repeat (80) @(negedge clk_50);
      end
      data_ena = 1'($urandom);
      parallel_data = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 8'hA5 : 8'hC3)
                                                   : 8'($urandom);
      fifo_full = ($urandom_range(0, 7) == 0);
      reset_n = ($urandom_range(0, 399) != 0);
    end
    reset_n = 1'b1;

    // Error counter saturation.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      send(8'hA5, 1'b0);
      repeat (TMO + 4) @(negedge clk_50);
    end
    chk("sat.dut0", 32'(err_cnt[0]), 32'hFF);
    chk("sat.dut1", 32'(err_cnt[1]), 32'hFF);

    // Reset mid-packet.
    send(8'hA5, 1'b0);
    send(8'h11, 1'b0);
    reset_n = 1'b0;
    @(negedge clk_50);
    for (int r = 0; r < 2; r++) begin
      chk("mid.wr_fifo", 32'(wr_fifo[r]), 32'd0);
      chk("mid.wr_data", 32'(wr_data[r]), 32'd0);
      chk("mid.pkt_done", 32'(pkt_done[r]), 32'd0);
      chk("mid.byte_idx", 32'(byte_idx[r]), 32'd0);
      chk("mid.in_pkt", 32'(in_pkt[r]), 32'd0);
      chk("mid.ovf_err", 32'(ovf_err[r]), 32'd0);
      chk("mid.tmo_err", 32'(tmo_err[r]), 32'd0);
      chk("mid.err_cnt", 32'(err_cnt[r]), 32'd0);
    end
    reset_n = 1'b1;
    repeat (10) @(negedge clk_50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
